// File: rtl/wrr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wrr_arbiter
// Description : Weighted round-robin / fixed-priority arbiter with per-owner
//               burst credit and registered one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
module wrr_arbiter #(
  parameter int N  = 4,
  parameter int CW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N*CW-1:0]      weight,
  input  logic                 fp_mode,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 grant_valid
);

  localparam int C_IW = $clog2(N);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [N-1:0]    r_grant, w_grant_nxt;
  logic [C_IW-1:0] r_owner, w_owner_nxt;
  logic [C_IW-1:0] r_ptr, w_ptr_nxt;
  logic [CW-1:0]   r_credit, w_credit_nxt;
  logic [C_IW-1:0] w_rr_idx, w_fp_idx, w_win;
  logic [CW-1:0]   w_win_weight;
  logic            w_any;
  logic            w_arb;

  // Round-robin: descending scan so the nearest requester after ptr wins.
  always_comb begin
    w_rr_idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(r_ptr) + k) % N]) begin
        w_rr_idx = C_IW'((int'(r_ptr) + k) % N);
      end
    end
  end

  always_comb begin
    w_fp_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_fp_idx = C_IW'(i);
      end
    end
  end

  assign w_any        = |req;
  assign w_win        = fp_mode ? w_fp_idx : w_rr_idx;
  assign w_win_weight = weight[int'(w_win)*CW +: CW];

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_owner_nxt  = r_owner;
    w_ptr_nxt    = r_ptr;
    w_credit_nxt = r_credit;
    w_arb        = 1'b0;

    case (r_state)
      S_IDLE: w_arb = 1'b1;
      S_BUSY: begin
        // Release on a dropped request or on the last credited transfer.
        if (!req[r_owner] || (r_credit == CW'(1))) begin
          w_arb = 1'b1;
        end else begin
          w_credit_nxt = r_credit - CW'(1);
        end
      end
      default: w_arb = 1'b1;
    endcase

    if (w_arb) begin
      if (w_any) begin
        w_state_nxt  = S_BUSY;
        w_grant_nxt  = {{(N-1){1'b0}}, 1'b1} << w_win;
        w_owner_nxt  = w_win;
        w_ptr_nxt    = w_win;
        w_credit_nxt = (w_win_weight == '0) ? CW'(1) : w_win_weight;
      end else begin
        w_state_nxt  = S_IDLE;
        w_grant_nxt  = '0;
        w_owner_nxt  = '0;
        w_credit_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_credit <= '0;
      r_ptr    <= C_IW'(N - 1);
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_owner  <= w_owner_nxt;
      r_credit <= w_credit_nxt;
      r_ptr    <= w_ptr_nxt;
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_owner;
  assign grant_valid = (r_state == S_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_wrr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wrr_arbiter
// Description : Scoreboard bench for wrr_arbiter (N=4, CW=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wrr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] weight;
  logic        fp_mode;
  logic [3:0]  grant;
  logic [1:0]  grant_id;
  logic        grant_valid;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  wrr_arbiter #(.N(4), .CW(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .weight      (weight),
    .fp_mode     (fp_mode),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] enc(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  // Reset for one edge with the given inputs, then release.
  task automatic do_reset(input logic [15:0] w, input logic fp, input logic [3:0] r);
    rst_n = 1'b0; weight = w; fp_mode = fp; req = r;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] e;
    rst_n = 1'b0; req = 4'b1111; weight = 16'h1111; fp_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (grant !== 4'b0 || grant_id !== 2'd0 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL test_reset: grant=%b id=%0d valid=%b expected 0000/0/0", grant, grant_id, grant_valid);
    end
    // First arbitration on the first cycle out of reset, then rotate.
    rst_n = 1'b1;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (grant !== e || grant_id !== enc(e) || grant_valid !== (|e)) begin
        errors++;
        $display("FAIL test_reset step %0d: grant=%b id=%0d valid=%b expected %b/%0d/%b", s, grant, grant_id, grant_valid, e, enc(e), |e);
      end
    end
  endtask

  task automatic test_weight2();
    logic [3:0] e;
    logic [3:0] seq [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    do_reset(16'h2222, 1'b0, 4'b1111);
    for (int s = 0; s < 9; s++) begin
      exp_q.push_back(seq[s]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (grant !== e || grant_id !== enc(e) || grant_valid !== (|e)) begin
        errors++;
        $display("FAIL test_weight2 step %0d: grant=%b id=%0d valid=%b expected %b/%0d/%b", s, grant, grant_id, grant_valid, e, enc(e), |e);
      end
    end
  endtask

  task automatic test_zero_weight();
    logic [3:0] e;
    logic [3:0] seq [10] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0010};
    do_reset(16'h0030, 1'b0, 4'b0011);
    for (int s = 0; s < 10; s++) begin
      exp_q.push_back(seq[s]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (grant !== e || grant_id !== enc(e) || grant_valid !== (|e)) begin
        errors++;
        $display("FAIL test_zero_weight step %0d: grant=%b id=%0d valid=%b expected %b/%0d/%b", s, grant, grant_id, grant_valid, e, enc(e), |e);
      end
    end
  endtask

  // Owner 2 (weight 5) drops its request after two transfers; requester 3 takes over.
  task automatic test_drop();
    logic [3:0] e;
    logic [3:0] reqs [6] = '{4'b1100, 4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b0000};
    logic [3:0] seq  [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0000};
    do_reset(16'h5555, 1'b0, 4'b1100);
    for (int s = 0; s < 6; s++) begin
      req = reqs[s];
      exp_q.push_back(seq[s]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (grant !== e || grant_id !== enc(e) || grant_valid !== (|e)) begin
        errors++;
        $display("FAIL test_drop step %0d: grant=%b id=%0d valid=%b expected %b/%0d/%b", s, grant, grant_id, grant_valid, e, enc(e), |e);
      end
    end
  endtask

  task automatic test_fixed_priority();
    logic [3:0] e;
    logic       fps [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] seq [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset(16'h1111, 1'b1, 4'b1111);
    for (int s = 0; s < 7; s++) begin
      fp_mode = fps[s];
      exp_q.push_back(seq[s]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (grant !== e || grant_id !== enc(e) || grant_valid !== (|e)) begin
        errors++;
        $display("FAIL test_fixed_priority step %0d: grant=%b id=%0d valid=%b expected %b/%0d/%b", s, grant, grant_id, grant_valid, e, enc(e), |e);
      end
    end
  endtask

  // Reset in the middle of a weight-4 burst, then a fresh burst of 4.
  task automatic test_reset_midburst();
    logic [3:0] e;
    logic       rsts [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] reqs [9] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011};
    logic [3:0] seq  [9] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0010};
    do_reset(16'h0040, 1'b0, 4'b0010);
    for (int s = 0; s < 9; s++) begin
      rst_n = rsts[s];
      req   = reqs[s];
      exp_q.push_back(seq[s]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (grant !== e || grant_id !== enc(e) || grant_valid !== (|e)) begin
        errors++;
        $display("FAIL test_reset_midburst step %0d: grant=%b id=%0d valid=%b expected %b/%0d/%b", s, grant, grant_id, grant_valid, e, enc(e), |e);
      end
    end
    rst_n = 1'b1;
  endtask

  // Idle with no requests, then weight changes mid-burst must not alter the credit.
  task automatic test_idle_weight_change();
    logic [3:0]  e;
    logic [3:0]  reqs [7] = '{4'b0000, 4'b0000, 4'b0100, 4'b0110, 4'b0110, 4'b0110, 4'b0110};
    logic [15:0] ws   [7] = '{16'h0300, 16'h0300, 16'h0300, 16'h0F10, 16'h0F10, 16'h0F10, 16'h0F10};
    logic [3:0]  seq  [7] = '{4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0100};
    do_reset(16'h0300, 1'b0, 4'b0000);
    for (int s = 0; s < 7; s++) begin
      req    = reqs[s];
      weight = ws[s];
      exp_q.push_back(seq[s]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (grant !== e || grant_id !== enc(e) || grant_valid !== (|e)) begin
        errors++;
        $display("FAIL test_idle_weight_change step %0d: grant=%b id=%0d valid=%b expected %b/%0d/%b", s, grant, grant_id, grant_valid, e, enc(e), |e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; weight = '0; fp_mode = 1'b0;
    test_reset();
    test_weight2();
    test_zero_weight();
    test_drop();
    test_fixed_priority();
    test_reset_midburst();
    test_idle_weight_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wrr_arbiter.md
WRR_ARBITER -- requirements
Module: wrr_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters; SHALL be >= 2.
REQ-002 Parameter CW, default 4: width of each per-requester weight and of the burst credit counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 req  input  N  request vector; bit i = requester i wants access.
REQ-006 weight  input  N*CW  per-requester burst weight; bits [i*CW +: CW] belong to requester i.
REQ-007 fp_mode  input  1  1 = fixed priority (index 0 highest); 0 = round robin.
REQ-008 grant  output  N  registered one-hot grant; all zero when idle.
REQ-009 grant_id  output  $clog2(N)  registered index of the granted requester; 0 when idle.
REQ-010 grant_valid  output  1  registered; equals |grant.

Function
REQ-011 States: IDLE (no owner) and BUSY (one owner holds grant); grant_valid SHALL be 1 exactly in BUSY.
REQ-012 Transfer: a cycle in BUSY where req[owner]=1.
REQ-013 Arbitration SHALL be evaluated in IDLE every cycle, and in BUSY only in a release cycle (REQ-017).
REQ-014 Round-robin search (fp_mode=0): first set bit of req scanning ptr+1, ptr+2, ... ptr (mod N); the current owner is therefore eligible only if no other requester is set.
REQ-015 Fixed-priority search (fp_mode=1): lowest set index of req; ptr is ignored but still updated. fp_mode is sampled only in arbitration cycles.
REQ-016 Winner SHALL appear on grant/grant_id/grant_valid the cycle after arbitration (1-cycle latency); ptr SHALL update to the winner index in the same edge; credit SHALL load weight[winner], with weight 0 treated as 1.
REQ-017 Release in BUSY: (a) req[owner]=0, or (b) transfer with credit == 1. A transfer with credit > 1 SHALL decrement credit and hold grant.
REQ-018 In a release cycle a new arbitration SHALL run on the same cycle's req; if any bit set, the next grant SHALL take effect at the next edge with no idle bubble; otherwise the next state SHALL be IDLE with grant = 0.
REQ-019 Grant SHALL never change while in BUSY except at a release; weight changes during a burst SHALL NOT affect the running credit.
REQ-020 grant SHALL be one-hot or zero at all times; grant_id SHALL match the set bit.
REQ-021 Credit arithmetic SHALL be unsigned CW-bit; credit SHALL never decrement below 1 (release occurs at 1).
REQ-022 With N not a power of two, ptr wrap from N-1 SHALL go to 0; no out-of-range index SHALL be granted.

Reset
REQ-023 While rst_n=0 at a clock edge: state IDLE, grant=0, grant_id=0, grant_valid=0, credit=0, ptr=N-1 (so requester 0 wins first round-robin search).
REQ-024 Reset asserted mid-burst SHALL abandon the burst; outputs SHALL be zero after that edge regardless of req.
REQ-025 First arbitration SHALL occur in the first cycle with rst_n=1.

Verification (N=4, CW=4)
REQ-026 Reset release with req=1111, all weights 1, fp_mode=0 -> grant 0001 one cycle later, then 0010, 0100, 1000, 0001 on successive cycles.
REQ-027 req=1111 held, all weights 2 -> grant sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001, with no zero cycle.
REQ-028 weight0=0, weight1=3, req=0011 held -> grant 0001 (1 cycle), 0010 (3 cycles), 0001 (1 cycle), repeating.
REQ-029 Owner 2 with weight 5 drops req after 2 transfers while req[3]=1 -> grant 1000 the cycle after the drop; grant_id=3; no bubble.
REQ-030 fp_mode=1, req=1111, weights 1 -> grant stays 0001 every cycle; switching fp_mode to 0 -> next grants 0010, 0100, 1000.
REQ-031 rst_n=0 for one cycle during a weight-4 burst of requester 1 -> grant=0 after that edge; after release with req=0010 -> grant 0010 one cycle later with fresh credit 4.
